// File: rtl/atm_pkg.sv
// Shared types and constants for the cashier transaction engine.
package atm_pkg;

  localparam int MONTO_W = 32;
  localparam int BAL_W   = 64;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/atm_alu.sv
// Balance arithmetic: saturating deposit or checked withdrawal; purely combinational.
// Latency: 0 cycles. Backpressure: none.
module atm_alu #(
  parameter int MONTO_W = 32,
  parameter int BAL_W   = 64
) (
  input  logic [BAL_W-1:0]   balance,
  input  logic [MONTO_W-1:0] monto,
  input  logic               tipo,
  output logic [BAL_W-1:0]   balance_nuevo,
  output logic               insuf
);
  import atm_pkg::*;

  logic [BAL_W-1:0] monto_ext;
  logic [BAL_W:0]   suma;

  always_comb begin
    monto_ext     = BAL_W'(monto);
    suma          = {1'b0, balance} + {1'b0, monto_ext};
    insuf         = 1'b0;
    balance_nuevo = balance;
    if (tipo == TIPO_DEPOSITO) begin
      // Carry out of the top bit means the account would wrap; clamp instead.
      balance_nuevo = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
    end else begin
      insuf         = (monto_ext > balance);
      balance_nuevo = balance - monto_ext;
    end
  end

endmodule

// File: rtl/atm_transaccion.sv
// One deposit/withdrawal per card session; result strobed 2 cycles after the card is seen.
// Latency: 2 cycles. Backpressure: none, the account store and dispenser must accept every pulse.
module atm_transaccion #(
  parameter int MONTO_W = atm_pkg::MONTO_W,
  parameter int BAL_W   = atm_pkg::BAL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tarjeta_recibida,
  input  logic               tipo_trans,
  input  logic [MONTO_W-1:0] monto,
  input  logic [BAL_W-1:0]   balance_inicial,
  output logic [BAL_W-1:0]   balance_actualizado,
  output logic               balance_stb,
  output logic               entregar_dinero,
  output logic               fondos_insuficientes
);
  import atm_pkg::*;

  estado_t            estado, estado_n;
  logic               tipo_q;
  logic [MONTO_W-1:0] monto_q;
  logic [BAL_W-1:0]   bal_q;
  logic               cargar;

  logic [BAL_W-1:0]   bal_alu;
  logic               insuf;

  logic [BAL_W-1:0]   bal_n;
  logic               stb_n, ent_n, fon_n;

  atm_alu #(
    .MONTO_W (MONTO_W),
    .BAL_W   (BAL_W)
  ) u_alu (
    .balance       (bal_q),
    .monto         (monto_q),
    .tipo          (tipo_q),
    .balance_nuevo (bal_alu),
    .insuf         (insuf)
  );

  always_comb begin
    estado_n = estado;
    cargar   = 1'b0;
    bal_n    = balance_actualizado;
    stb_n    = 1'b0;
    ent_n    = 1'b0;
    fon_n    = fondos_insuficientes;
    case (estado)
      IDLE: begin
        if (tarjeta_recibida) begin
          estado_n = EXEC;
          cargar   = 1'b1;
        end
      end
      EXEC: begin
        // Commits even if the card was pulled meanwhile.
        estado_n = DONE;
        if (!insuf) begin
          bal_n = bal_alu;
          stb_n = 1'b1;
          ent_n = (tipo_q == TIPO_RETIRO);
        end else begin
          fon_n = 1'b1;
        end
      end
      DONE: begin
        if (!tarjeta_recibida) begin
          estado_n = IDLE;
          fon_n    = 1'b0;
        end
      end
      default: estado_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado               <= IDLE;
      tipo_q               <= 1'b0;
      monto_q              <= '0;
      bal_q                <= '0;
      balance_actualizado  <= '0;
      balance_stb          <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
    end else begin
      estado               <= estado_n;
      balance_actualizado  <= bal_n;
      balance_stb          <= stb_n;
      entregar_dinero      <= ent_n;
      fondos_insuficientes <= fon_n;
      if (cargar) begin
        tipo_q  <= tipo_trans;
        monto_q <= monto;
        bal_q   <= balance_inicial;
      end
    end
  end

endmodule

// File: tb/tb_atm_transaccion.sv
// Scoreboard bench for atm_transaccion: expected results queued at stimulus time, popped on output.
module tb_atm_transaccion;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tarjeta_recibida = 1'b0;
  logic        tipo_trans = 1'b0;
  logic [31:0] monto = '0;
  logic [63:0] balance_inicial = '0;
  logic [63:0] balance_actualizado;
  logic        balance_stb;
  logic        entregar_dinero;
  logic        fondos_insuficientes;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] bal;
    logic        stb;
    logic        ent;
    logic        fon;
  } res_t;

  res_t        exp_q[$];
  logic [63:0] modelo_bal = '0;

  atm_transaccion #(.MONTO_W(32), .BAL_W(64)) dut (
    .clk                  (clk),
    .reset                (reset),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_trans           (tipo_trans),
    .monto                (monto),
    .balance_inicial      (balance_inicial),
    .balance_actualizado  (balance_actualizado),
    .balance_stb          (balance_stb),
    .entregar_dinero      (entregar_dinero),
    .fondos_insuficientes (fondos_insuficientes)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one transaction, kept in 65-bit arithmetic.
  task automatic push_expected(input logic [63:0] bal, input logic [31:0] m, input logic tipo);
    res_t        e;
    logic [64:0] s;
    if (tipo == 1'b0) begin
      s = {1'b0, bal} + {33'd0, m};
      e.bal = s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
      e.stb = 1'b1; e.ent = 1'b0; e.fon = 1'b0;
      modelo_bal = e.bal;
    end else if ({32'd0, m} > bal) begin
      e.bal = modelo_bal;
      e.stb = 1'b0; e.ent = 1'b0; e.fon = 1'b1;
    end else begin
      e.bal = bal - {32'd0, m};
      e.stb = 1'b1; e.ent = 1'b1; e.fon = 1'b0;
      modelo_bal = e.bal;
    end
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; the next rising edge captures the session.
  task automatic start_session(input logic [63:0] bal, input logic [31:0] m, input logic tipo);
    balance_inicial  = bal;
    monto            = m;
    tipo_trans       = tipo;
    tarjeta_recibida = 1'b1;
    push_expected(bal, m, tipo);
  endtask

  task automatic wait_result(output logic found, output int lat);
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (balance_stb || fondos_insuficientes) begin
        found = 1'b1;
        lat   = i;
        break;
      end
    end
  endtask

  task automatic end_session();
    tarjeta_recibida = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (balance_actualizado !== 64'd0) begin
      n_err++; $display("FAIL reset_balance: got %0d want 0", balance_actualizado);
    end
    n_cmp++;
    if ({balance_stb, entregar_dinero, fondos_insuficientes} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {balance_stb, entregar_dinero, fondos_insuficientes});
    end
    reset = 1'b1;
    modelo_bal = '0;
    @(negedge clk);
  endtask

  task automatic test_deposit();
    logic found; int lat; res_t e;
    start_session(64'd1000, 32'd250, 1'b0);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || lat != 2) begin
      n_err++; $display("FAIL deposit_latency: got found=%0b lat=%0d want lat=2", found, lat);
    end
    n_cmp++;
    if ({balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes} !== {e.bal, e.stb, e.ent, e.fon}) begin
      n_err++; $display("FAIL deposit_result: got bal=%0d stb=%b ent=%b fon=%b want bal=%0d stb=%b ent=%b fon=%b",
        balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes, e.bal, e.stb, e.ent, e.fon);
    end
    @(negedge clk);
    n_cmp++;
    if ({balance_stb, entregar_dinero} !== 2'b00) begin
      n_err++; $display("FAIL deposit_pulse_width: got stb/ent=%b want 00", {balance_stb, entregar_dinero});
    end
    end_session();
  endtask

  task automatic test_withdraw();
    logic found; int lat; res_t e;
    start_session(64'd1000, 32'd400, 1'b1);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || lat != 2) begin
      n_err++; $display("FAIL withdraw_latency: got found=%0b lat=%0d want lat=2", found, lat);
    end
    n_cmp++;
    if ({balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes} !== {e.bal, e.stb, e.ent, e.fon}) begin
      n_err++; $display("FAIL withdraw_result: got bal=%0d stb=%b ent=%b fon=%b want bal=%0d stb=%b ent=%b fon=%b",
        balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes, e.bal, e.stb, e.ent, e.fon);
    end
    @(negedge clk);
    n_cmp++;
    if ({balance_stb, entregar_dinero} !== 2'b00) begin
      n_err++; $display("FAIL withdraw_pulse_width: got stb/ent=%b want 00", {balance_stb, entregar_dinero});
    end
    end_session();
  endtask

  task automatic test_insufficient();
    logic found; int lat; res_t e; int n_stb;
    start_session(64'd300, 32'd301, 1'b1);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || lat != 2) begin
      n_err++; $display("FAIL insuf_latency: got found=%0b lat=%0d want lat=2", found, lat);
    end
    n_cmp++;
    if ({balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes} !== {e.bal, e.stb, e.ent, e.fon}) begin
      n_err++; $display("FAIL insuf_result: got bal=%0d stb=%b ent=%b fon=%b want bal=%0d stb=%b ent=%b fon=%b",
        balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes, e.bal, e.stb, e.ent, e.fon);
    end
    n_stb = 0;
    repeat (3) begin
      @(negedge clk);
      if (balance_stb || entregar_dinero) n_stb++;
    end
    n_cmp++;
    if (fondos_insuficientes !== 1'b1 || n_stb != 0) begin
      n_err++; $display("FAIL insuf_hold: got fon=%b strobes=%0d want fon=1 strobes=0", fondos_insuficientes, n_stb);
    end
    end_session();
    n_cmp++;
    if (fondos_insuficientes !== 1'b0) begin
      n_err++; $display("FAIL insuf_clear: got fon=%b want 0", fondos_insuficientes);
    end
  endtask

  task automatic test_boundary();
    logic found; int lat; res_t e;
    start_session(64'd500, 32'd500, 1'b1);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || {balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes} !== {e.bal, e.stb, e.ent, e.fon}) begin
      n_err++; $display("FAIL exact_withdraw: got found=%0b bal=%0d stb=%b ent=%b fon=%b want bal=%0d stb=%b ent=%b fon=%b",
        found, balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes, e.bal, e.stb, e.ent, e.fon);
    end
    end_session();
    start_session(64'hFFFF_FFFF_FFFF_FFFD, 32'd5, 1'b0);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || {balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes} !== {e.bal, e.stb, e.ent, e.fon}) begin
      n_err++; $display("FAIL saturate: got found=%0b bal=%h stb=%b ent=%b fon=%b want bal=%h stb=%b ent=%b fon=%b",
        found, balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes, e.bal, e.stb, e.ent, e.fon);
    end
    end_session();
    start_session(64'd77, 32'd0, 1'b1);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || {balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes} !== {e.bal, e.stb, e.ent, e.fon}) begin
      n_err++; $display("FAIL zero_withdraw: got found=%0b bal=%0d stb=%b ent=%b fon=%b want bal=%0d stb=%b ent=%b fon=%b",
        found, balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes, e.bal, e.stb, e.ent, e.fon);
    end
    end_session();
  endtask

  // Card held for 10 cycles while the inputs are scrambled after capture.
  task automatic test_session_hold();
    int n_stb; res_t e;
    n_stb = 0;
    start_session(64'd1000, 32'd1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        balance_inicial = 64'd5;
        monto           = 32'd7;
        tipo_trans      = 1'b0;
      end
      if (balance_stb) begin
        n_stb++;
        if (n_stb == 1) begin
          e = exp_q.pop_front();
          n_cmp++;
          if ({balance_actualizado, entregar_dinero} !== {e.bal, e.ent}) begin
            n_err++; $display("FAIL hold_result: got bal=%0d ent=%b want bal=%0d ent=%b",
              balance_actualizado, entregar_dinero, e.bal, e.ent);
          end
        end
      end
    end
    n_cmp++;
    if (n_stb != 1) begin
      n_err++; $display("FAIL hold_strobe_count: got %0d want 1", n_stb);
    end
    if (n_stb == 0) void'(exp_q.pop_front());
    end_session();
  endtask

  task automatic test_drop_in_exec();
    res_t e;
    start_session(64'd2000, 32'd10, 1'b0);
    @(negedge clk);
    tarjeta_recibida = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({balance_actualizado, balance_stb, entregar_dinero} !== {e.bal, e.stb, e.ent}) begin
      n_err++; $display("FAIL drop_in_exec: got bal=%0d stb=%b ent=%b want bal=%0d stb=%b ent=%b",
        balance_actualizado, balance_stb, entregar_dinero, e.bal, e.stb, e.ent);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic found; int lat; res_t e;
    start_session(64'd100, 32'd30, 1'b1);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || {balance_actualizado, entregar_dinero} !== {e.bal, e.ent}) begin
      n_err++; $display("FAIL b2b_first: got found=%0b bal=%0d ent=%b want bal=%0d ent=%b",
        found, balance_actualizado, entregar_dinero, e.bal, e.ent);
    end
    end_session();
    start_session(64'd50, 32'd20, 1'b0);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || lat != 2 || {balance_actualizado, entregar_dinero} !== {e.bal, e.ent}) begin
      n_err++; $display("FAIL b2b_second: got found=%0b lat=%0d bal=%0d ent=%b want lat=2 bal=%0d ent=%b",
        found, lat, balance_actualizado, entregar_dinero, e.bal, e.ent);
    end
    end_session();
  endtask

  task automatic test_reset_exec();
    logic found; int lat; res_t e; int n_stb;
    balance_inicial  = 64'd1000;
    monto            = 32'd100;
    tipo_trans       = 1'b1;
    tarjeta_recibida = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes} !== 67'd0) begin
      n_err++; $display("FAIL reset_in_exec: got bal=%0d stb=%b ent=%b fon=%b want all 0",
        balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes);
    end
    modelo_bal = '0;
    tarjeta_recibida = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_stb = 0;
    repeat (4) begin
      @(negedge clk);
      if (balance_stb || entregar_dinero) n_stb++;
    end
    n_cmp++;
    if (n_stb != 0) begin
      n_err++; $display("FAIL reset_no_strobe: got %0d strobes want 0", n_stb);
    end
    start_session(64'd10, 32'd3, 1'b0);
    wait_result(found, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || lat != 2 || balance_actualizado !== e.bal) begin
      n_err++; $display("FAIL reset_then_session: got found=%0b lat=%0d bal=%0d want lat=2 bal=%0d",
        found, lat, balance_actualizado, e.bal);
    end
    end_session();
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_withdraw();
    test_insufficient();
    test_boundary();
    test_session_hold();
    test_drop_in_exec();
    test_back_to_back();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
